// File: rtl/shift_pkg.sv
// Shared constants and types for the shared barrel-shifter arbiter slice.
package shift_pkg;

  localparam int unsigned SHIFT_AMT_W  = 5;
  localparam int unsigned SHIFT_DATA_W = 32;
  localparam int unsigned RSP_ID_W     = 2;

  localparam logic [1:0] SHIFT_SLL  = 2'b00;
  localparam logic [1:0] SHIFT_SRL  = 2'b01;
  localparam logic [1:0] SHIFT_SRA  = 2'b10;
  localparam logic [1:0] SHIFT_ROTR = 2'b11;

  // Occupancy of the one-entry result register.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/mips32_shift.sv
// Combinational MIPS32 barrel shifter: SLL, SRL, SRA and ROTR by 0..31.
module mips32_shift
  import shift_pkg::*;
(
  input  logic [SHIFT_DATA_W-1:0] data_i,
  input  logic [SHIFT_AMT_W-1:0]  amount_i,
  input  logic [1:0]              op_i,
  output logic [SHIFT_DATA_W-1:0] result_o
);

  // Select the shift flavour; amount 0 falls out as a pass-through for every op.
  always_comb begin
    result_o = data_i;
    unique case (op_i)
      SHIFT_SLL:  result_o = data_i << amount_i;
      SHIFT_SRL:  result_o = data_i >> amount_i;
      SHIFT_SRA:  result_o = $unsigned($signed(data_i) >>> amount_i);
      SHIFT_ROTR: result_o = (data_i >> amount_i)
                           | (data_i << (6'd32 - {1'b0, amount_i}));
      default:    result_o = data_i;
    endcase
  end

endmodule

// File: rtl/shift_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
module shift_rr_arbiter
  import shift_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic                enable_i,
  input  logic                advance_i,
  output logic [NUM_REQ-1:0]  grant_o,
  output logic [RSP_ID_W-1:0] idx_o
);

  logic [RSP_ID_W-1:0] ptr_q, ptr_d;
  logic                found;

  // Search from the pointer to the top, then wrap to the requesters below it.
  always_comb begin
    found = 1'b0;
    idx_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && (i >= 32'(ptr_q)) && req_i[i]) begin
        found = 1'b1;
        idx_o = RSP_ID_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && (i < 32'(ptr_q)) && req_i[i]) begin
        found = 1'b1;
        idx_o = RSP_ID_W'(i);
      end
    end
    grant_o = '0;
    if (found && enable_i) begin
      grant_o[idx_o] = 1'b1;
    end
  end

  // The pointer only moves past a winner that was actually accepted.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      if (idx_o == RSP_ID_W'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = idx_o + RSP_ID_W'(1);
      end
    end
  end

  // Pointer register; reset gives requester 0 top priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/shift_unit_arbiter.sv
// Shares one mips32_shift between NUM_REQ requesters behind a round-robin
// grant, with the result held in a one-entry valid/ready output register.
module shift_unit_arbiter
  import shift_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TAG_W   = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*SHIFT_DATA_W-1:0]  req_data,
  input  logic [NUM_REQ*SHIFT_AMT_W-1:0]   req_amount,
  input  logic [NUM_REQ*2-1:0]             req_op,
  input  logic [NUM_REQ*TAG_W-1:0]         req_tag,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [SHIFT_DATA_W-1:0]          rsp_data,
  output logic [RSP_ID_W-1:0]              rsp_id,
  output logic [TAG_W-1:0]                 rsp_tag
);

  slot_state_e              state_q;
  logic [SHIFT_DATA_W-1:0]  data_q;
  logic [RSP_ID_W-1:0]      id_q;
  logic [TAG_W-1:0]         tag_q;

  logic                     slot_free;
  logic                     accept;
  logic [NUM_REQ-1:0]       grant;
  logic [RSP_ID_W-1:0]      gnt_idx;
  logic [SHIFT_DATA_W-1:0]  sel_data;
  logic [SHIFT_AMT_W-1:0]   sel_amount;
  logic [1:0]               sel_op;
  logic [TAG_W-1:0]         sel_tag;
  logic [SHIFT_DATA_W-1:0]  shift_result;

  // rsp_ready feeds req_ready combinationally so a full slot drains and refills in one edge.
  // rst_n gates the enable so no requester sees ready while reset is held.
  always_comb begin
    slot_free = (state_q == SLOT_EMPTY) || rsp_ready;
  end

  shift_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_valid),
    .enable_i  (slot_free && rst_n),
    .advance_i (accept),
    .grant_o   (grant),
    .idx_o     (gnt_idx)
  );

  // Grant drives ready directly; an accept is a granted requester that is valid.
  always_comb begin
    req_ready = grant;
    accept    = |(req_valid & grant);
  end

  // Route the granted requester's operand, amount, op and tag to the shared shifter.
  always_comb begin
    sel_data   = '0;
    sel_amount = '0;
    sel_op     = '0;
    sel_tag    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (32'(gnt_idx) == i) begin
        sel_data   = req_data[i*SHIFT_DATA_W +: SHIFT_DATA_W];
        sel_amount = req_amount[i*SHIFT_AMT_W +: SHIFT_AMT_W];
        sel_op     = req_op[i*2 +: 2];
        sel_tag    = req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  mips32_shift u_shift (
    .data_i   (sel_data),
    .amount_i (sel_amount),
    .op_i     (sel_op),
    .result_o (shift_result)
  );

  // Output slot FSM: load on accept, empty on a drain with no refill, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      id_q    <= '0;
      tag_q   <= '0;
    end else begin
      unique case (state_q)
        SLOT_EMPTY: begin
          if (accept) begin
            state_q <= SLOT_FULL;
            data_q  <= shift_result;
            id_q    <= gnt_idx;
            tag_q   <= sel_tag;
          end
        end
        SLOT_FULL: begin
          if (accept) begin
            data_q <= shift_result;
            id_q   <= gnt_idx;
            tag_q  <= sel_tag;
          end else if (rsp_ready) begin
            state_q <= SLOT_EMPTY;
          end
        end
        default: state_q <= SLOT_EMPTY;
      endcase
    end
  end

  // Response outputs come straight from registers.
  always_comb begin
    rsp_valid = (state_q == SLOT_FULL);
    rsp_data  = data_q;
    rsp_id    = id_q;
    rsp_tag   = tag_q;
  end

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed bench for shift_unit_arbiter with NUM_REQ=2, TAG_W=4.
module tb_shift_unit_arbiter;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned TAG_W   = 4;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_data;
  logic [9:0]  req_amount;
  logic [3:0]  req_op;
  logic [7:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_tag;

  int n_total;
  int n_bad;

  shift_unit_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TAG_W   (TAG_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_amount (req_amount),
    .req_op     (req_op),
    .req_tag    (req_tag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_tag    (rsp_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int unsigned i, input logic v, input logic [31:0] d,
                         input logic [4:0] a, input logic [1:0] op, input logic [3:0] t);
    req_valid[i]          = v;
    req_data[i*32 +: 32]  = d;
    req_amount[i*5 +: 5]  = a;
    req_op[i*2 +: 2]      = op;
    req_tag[i*4 +: 4]     = t;
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [31:0] d,
                         input logic [1:0] id, input logic [3:0] t);
    chk({tag, ".valid"}, 32'(rsp_valid), 32'(v));
    chk({tag, ".data"},  rsp_data, d);
    chk({tag, ".id"},    32'(rsp_id), 32'(id));
    chk({tag, ".tag"},   32'(rsp_tag), 32'(t));
  endtask

  logic [1:0]  t2_op  [4] = '{2'b10, 2'b01, 2'b00, 2'b11};
  logic [31:0] t2_exp [4] = '{32'hC0000000, 32'h40000000, 32'h00000002, 32'hC0000000};

  initial begin
    n_total    = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    rsp_ready  = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    req_amount = '0;
    req_op     = '0;
    req_tag    = '0;

    // 1. reset with both requesters valid
    set_req(0, 1'b1, 32'h11111111, 5'd0, 2'b00, 4'h1);
    set_req(1, 1'b1, 32'h22222222, 5'd0, 2'b00, 4'h2);
    tick();
    tick();
    chk("rst.valid", 32'(rsp_valid), 32'd0);
    chk("rst.ready", 32'(req_ready), 32'd0);
    chk("rst.data",  rsp_data, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rel.ready", 32'(req_ready), 32'b01);
    req_valid = '0;
    tick();
    chk("rel.idle", 32'(rsp_valid), 32'd0);

    // 2. req0 alone through each op, one cycle latency
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b1, 32'h80000001, 5'd1, t2_op[k], 4'(k + 5));
      #1;
      chk("op.ready", 32'(req_ready), 32'b01);
      tick();
      chk_rsp("op", 1'b1, t2_exp[k], 2'd0, 4'(k + 5));
    end
    req_valid = '0;
    #1;
    chk("op.noready", 32'(req_ready), 32'd0);
    tick();
    chk("op.drain", 32'(rsp_valid), 32'd0);

    // 3. both valid: strict alternation from requester 0, back to back
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_req(0, 1'b1, 32'h00000001, 5'd4, 2'b00, 4'h1);
    set_req(1, 1'b1, 32'hF0000000, 5'd4, 2'b10, 4'h2);
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("rr.ready", 32'(req_ready), (c % 2 == 0) ? 32'b01 : 32'b10);
      tick();
      if (c % 2 == 0) chk_rsp("rr", 1'b1, 32'h00000010, 2'd0, 4'h1);
      else            chk_rsp("rr", 1'b1, 32'hFF000000, 2'd1, 4'h2);
    end
    req_valid[0] = 1'b0;
    #1;
    chk("solo1.ready", 32'(req_ready), 32'b10);
    tick();
    chk_rsp("solo1", 1'b1, 32'hFF000000, 2'd1, 4'h2);
    req_valid[0] = 1'b1;
    #1;
    chk("fair.ready", 32'(req_ready), 32'b01);
    req_valid = '0;
    tick();
    chk("fair.drain", 32'(rsp_valid), 32'd0);

    // 4. backpressure holds the result, then drain and refill on one edge
    set_req(0, 1'b1, 32'h12345678, 5'd8, 2'b01, 4'h3);
    rsp_ready = 1'b0;
    #1;
    chk("bp.ready0", 32'(req_ready), 32'b01);
    tick();
    chk_rsp("bp.load", 1'b1, 32'h00123456, 2'd0, 4'h3);
    set_req(0, 1'b1, 32'h000000FF, 5'd8, 2'b00, 4'h4);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp.hold.ready", 32'(req_ready), 32'd0);
      chk("bp.hold.data",  rsp_data, 32'h00123456);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp.comb.ready", 32'(req_ready), 32'b01);
    tick();
    chk_rsp("bp.refill", 1'b1, 32'h0000FF00, 2'd0, 4'h4);
    req_valid = '0;
    tick();
    chk("bp.drain", 32'(rsp_valid), 32'd0);

    // 5. amount boundaries
    for (int op = 0; op < 4; op++) begin
      set_req(0, 1'b1, 32'hDEADBEEF, 5'd0, 2'(op), 4'(op));
      tick();
      chk("amt0", rsp_data, 32'hDEADBEEF);
    end
    set_req(0, 1'b1, 32'h80000000, 5'd31, 2'b10, 4'h7);
    tick();
    chk("sra31", rsp_data, 32'hFFFFFFFF);
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 32'h12345678, 5'd4, 2'b11, 4'h9);
    tick();
    chk_rsp("rotr4", 1'b1, 32'h81234567, 2'd1, 4'h9);
    set_req(1, 1'b1, 32'h80000000, 5'd31, 2'b01, 4'hB);
    tick();
    chk("srl31", rsp_data, 32'h00000001);
    req_valid = '0;
    tick();

    // 6. async reset while full discards the result and the pointer
    set_req(0, 1'b1, 32'hCAFEF00D, 5'd0, 2'b00, 4'hA);
    rsp_ready = 1'b0;
    tick();
    req_valid = 2'b11;
    chk_rsp("full", 1'b1, 32'hCAFEF00D, 2'd0, 4'hA);
    #2;
    rst_n = 1'b0;
    #1;
    chk_rsp("arst", 1'b0, 32'h0, 2'd0, 4'h0);
    chk("arst.ready", 32'(req_ready), 32'd0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("arst.ptr", 32'(req_ready), 32'b01);
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    chk_rsp("arst.gone", 1'b0, 32'h0, 2'd0, 4'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
